// File: rtl/sqrt_iter.sv
// Iterative digit-by-digit integer square root, BPC root bits per cycle, valid/ready on both sides.
// Optional remainder output port enabled by defining SQRT_REM_OUT_EN.
module sqrt_iter #(
  parameter int IN_W = 31,
  parameter int R_W  = (IN_W + 1) / 2,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [R_W-1:0]  out_root
`ifdef SQRT_REM_OUT_EN
  ,
  output logic [R_W:0]    out_rem
`endif
);

  localparam int ITER  = R_W / BPC;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SH_W  = 2 * R_W;
  localparam int REM_W = R_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [R_W-1:0]    root_q, root_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [SH_W-1:0]   sh_v;
  logic [R_W-1:0]    root_v;
  logic [REM_W-1:0]  rem_v;
  logic [REM_W-1:0]  trial_v;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sh_v    = sh_q;
    root_v  = root_q;
    rem_v   = rem_q;
    trial_v = '0;

    // BPC recurrence steps chained in one cycle; partial remainder never exceeds REM_W bits
    for (int b = 0; b < BPC; b++) begin
      rem_v   = (rem_v << 2) | REM_W'(sh_v[SH_W-1 -: 2]);
      sh_v    = sh_v << 2;
      trial_v = ({2'b00, root_v} << 2) | REM_W'(1);
      if (rem_v >= trial_v) begin
        rem_v  = rem_v - trial_v;
        root_v = {root_v[R_W-2:0], 1'b1};
      end else begin
        root_v = {root_v[R_W-2:0], 1'b0};
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sh_d            = '0;
          sh_d[IN_W-1:0]  = in_x;
          root_d          = '0;
          rem_d           = '0;
          cnt_d           = CNT_W'(ITER - 1);
          state_d         = CALC;
        end
      end
      CALC: begin
        sh_d   = sh_v;
        root_d = root_v;
        rem_d  = rem_v;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = root_q;
`ifdef SQRT_REM_OUT_EN
  assign out_rem   = rem_q[R_W:0];
`endif

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: default, BPC=2 and IN_W=16 instances checked against a floor-sqrt model.
module tb_sqrt_iter;

  logic clk;
  logic rst_n;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [30:0] in_x_a;
  logic [15:0] root_a;
  logic [16:0] rem_a;

  logic        in_valid_bc, out_ready_bc;
  logic        in_ready_b, out_valid_b, in_ready_c, out_valid_c;
  logic [30:0] in_x_b;
  logic [15:0] in_x_c;
  logic [15:0] root_b;
  logic [16:0] rem_b;
  logic [7:0]  root_c;
  logic [8:0]  rem_c;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit alive = 0;
  int acc_a = 0;

  longint unsigned qx[3][$];
  int              qa[3][$];

  sqrt_iter u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_x(in_x_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_root(root_a)
`ifdef SQRT_REM_OUT_EN
    , .out_rem(rem_a)
`endif
  );

  sqrt_iter #(.IN_W(31), .BPC(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_bc), .in_ready(in_ready_b), .in_x(in_x_b),
    .out_valid(out_valid_b), .out_ready(out_ready_bc), .out_root(root_b)
`ifdef SQRT_REM_OUT_EN
    , .out_rem(rem_b)
`endif
  );

  sqrt_iter #(.IN_W(16), .BPC(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_bc), .in_ready(in_ready_c), .in_x(in_x_c),
    .out_valid(out_valid_c), .out_ready(out_ready_bc), .out_root(root_c)
`ifdef SQRT_REM_OUT_EN
    , .out_rem(rem_c)
`endif
  );

`ifndef SQRT_REM_OUT_EN
  assign rem_a = '0;
  assign rem_b = '0;
  assign rem_c = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // Reference: largest r with r*r <= x, by binary search
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'h1_0000_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input int iter, input bit iv, input bit ir, input bit ov,
                     input bit ordy, input longint unsigned xin, input longint unsigned root,
                     input longint unsigned rem);
    bit exp_ov;
    longint unsigned r;
    if (!rst_n) begin
      chk($sformatf("rst_in_ready[%0d]", id), ir, 0);
      chk($sformatf("rst_out_valid[%0d]", id), ov, 0);
      chk($sformatf("rst_root[%0d]", id), root, 0);
`ifdef SQRT_REM_OUT_EN
      chk($sformatf("rst_rem[%0d]", id), rem, 0);
`endif
      qx[id].delete();
      qa[id].delete();
      return;
    end
    exp_ov = (qx[id].size() > 0) && (cyc - qa[id][0] >= iter);
    chk($sformatf("out_valid[%0d]", id), ov, exp_ov);
    chk($sformatf("in_ready[%0d]", id), ir, alive && (qx[id].size() == 0));
    if (ov && exp_ov) begin
      r = isqrt(qx[id][0]);
      chk($sformatf("root[%0d] x=%0d", id, qx[id][0]), root, r);
`ifdef SQRT_REM_OUT_EN
      chk($sformatf("root2_plus_rem[%0d] x=%0d", id, qx[id][0]), root * root + rem, qx[id][0]);
`endif
      if (ordy) begin
        void'(qx[id].pop_front());
        void'(qa[id].pop_front());
      end
    end
    if (iv && ir) begin
      qx[id].push_back(xin);
      qa[id].push_back(cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 16, in_valid_a, in_ready_a, out_valid_a, out_ready_a, in_x_a, root_a, rem_a);
    mon(1, 8, in_valid_bc, in_ready_b, out_valid_b, out_ready_bc, in_x_b, root_b, rem_b);
    mon(2, 8, in_valid_bc, in_ready_c, out_valid_c, out_ready_bc, in_x_c, root_c, rem_c);
  end

  task automatic send_a(input logic [30:0] x);
    bit ok = 0;
    in_x_a = x;
    in_valid_a = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready_a) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    acc_a = cyc;
    if (!ok) chk("a_accept_timeout", 0, 1);
  endtask

  task automatic wait_ov_a(output int lat);
    bit ok = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (out_valid_a) begin
        ok = 1;
        break;
      end
    end
    lat = cyc - acc_a;
    if (!ok) chk("a_out_valid_timeout", 0, 1);
  endtask

  task automatic direct_a(input logic [30:0] x, input longint unsigned er,
                          input longint unsigned erem, input string nm);
    int lat;
    send_a(x);
    wait_ov_a(lat);
    chk({nm, "_latency"}, lat, 16);
    chk({nm, "_root"}, root_a, er);
`ifdef SQRT_REM_OUT_EN
    chk({nm, "_rem"}, rem_a, erem);
`else
    if (erem > 2 * er) chk({nm, "_table_rem"}, erem, 2 * er);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic send_bc(input logic [30:0] xb, input logic [15:0] xc);
    bit ok = 0;
    in_x_b = xb;
    in_x_c = xc;
    in_valid_bc = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready_b && in_ready_c) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_bc = 1'b0;
    if (!ok) chk("bc_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (qx[0].size() == 0 && qx[1].size() == 0 && qx[2].size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_acc;
    bit done;
    rst_n = 1'b0;
    in_valid_a = 0; in_x_a = '0; out_ready_a = 1'b1;
    in_valid_bc = 0; in_x_b = '0; in_x_c = '0; out_ready_bc = 1'b1;

    chk("model_ffff", isqrt(64'hFFFF), 255);
    chk("model_max31", isqrt(64'h7FFF_FFFF), 46340);
    chk("model_3f0a", isqrt(64'h3F0A_C435), 32521);
    chk("model_zero", isqrt(0), 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    direct_a(31'h0000FFFF, 255, 510, "d_ffff");
    prev_acc = acc_a;
    direct_a(31'h0000FA43, 253, 58, "d_fa43");
    chk("throughput", acc_a - prev_acc, 18);
    direct_a(31'h0131FFFF, 4478, 1531, "d_0131");
    direct_a(31'h3F0AC435, 32521, 54756, "d_3f0a");
    direct_a(31'h00000000, 0, 0, "d_zero");
    direct_a(31'h7FFFFFFF, 46340, 88047, "d_max");

    // Backpressure: hold the result for 20 cycles while a stray in_valid is offered
    begin
      int lat;
      out_ready_a = 1'b0;
      send_a(31'h3F0AC435);
      wait_ov_a(lat);
      chk("bp_latency", lat, 16);
      for (int i = 0; i < 20; i++) begin
        chk("bp_valid", out_valid_a, 1);
        chk("bp_root", root_a, 32521);
`ifdef SQRT_REM_OUT_EN
        chk("bp_rem", rem_a, 54756);
`endif
        chk("bp_in_ready", in_ready_a, 0);
        @(posedge clk);
        #1;
        in_valid_a = (i >= 4 && i < 7);
        in_x_a = 31'h0000FFFF;
        @(negedge clk);
      end
      in_valid_a = 1'b0;
      @(posedge clk);
      #1 out_ready_a = 1'b1;
      @(negedge clk);
      chk("bp_valid_before_hs", out_valid_a, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_valid_after_hs", out_valid_a, 0);
      chk("bp_ready_after_hs", in_ready_a, 1);
      repeat (20) @(posedge clk);
      #1;
    end

    // Reset in the fifth CALC cycle
    send_a(31'h7FFFFFFF);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_root", root_a, 0);
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_ready", in_ready_a, 0);
`ifdef SQRT_REM_OUT_EN
    chk("mid_rst_rem", rem_a, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", in_ready_a, 0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", in_ready_a, 1);
    direct_a(31'h0000FFFF, 255, 510, "d_after_rst");

    // Random traffic on the default instance with random backpressure
    done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          if ($urandom_range(0, 3) == 0) send_a(31'($urandom_range(0, 2000)));
          else send_a(31'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready_a = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_a = 1'b1;
    drain();

    // Random traffic on the BPC=2 and IN_W=16 instances in lockstep
    done = 0;
    fork
      begin
        for (int n = 0; n < 2000; n++) begin
          if (n == 0) send_bc(31'h0, 16'h0);
          else if (n == 1) send_bc(31'h7FFFFFFF, 16'hFFFF);
          else begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_bc(31'($urandom), 16'($urandom));
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready_bc = ($urandom_range(0, 4) != 0);
        end
      end
    join
    out_ready_bc = 1'b1;
    drain();

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
